mem_access_ctrl: RTL and testbench

Sequences data-memory accesses for the MEM stage. It captures a load/store presented by the EX/MEM pipeline register and drives a req/ack data-memory port. It stalls the front of the pipeline, including the EX/MEM register, until the access completes. It also generates byte enables and store-data lanes from funct3, and sign/zero-extends load data before it goes to MEM/WB.

---
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one load/store at a time on a req/ack port; min 2 stall cycles, +1 per ack-delay cycle.
// Back-pressure: stall_out freezes PC..EX/MEM while issuing/waiting; misaligned accesses flag an error without stalling.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] store_data_in,
    input  logic [2:0]  funct3_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misalign_err_out,
    output logic        bus_err_out,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic       TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [31:0] ldata_q, ldata_d;

    logic        in_idle, in_wait, in_done;
    logic        access, sz_byte, sz_half, misaligned, start;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign in_idle = (state_q == ST_IDLE);
    assign in_wait = (state_q == ST_WAIT);
    assign in_done = (state_q == ST_DONE);

    // funct3[1:0] encodes size: 00 byte, 01 half, anything else behaves as a word.
    always_comb begin
        access     = MemRead_in | MemWrite_in;
        sz_byte    = (funct3_in[1:0] == 2'b00);
        sz_half    = (funct3_in[1:0] == 2'b01);
        misaligned = (sz_half & ALU_in[0]) |
                     (~sz_byte & ~sz_half & (ALU_in[1:0] != 2'b00));
        start      = in_idle & access & ~misaligned;
    end

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = store_data_in;
        if (MemWrite_in) begin
            if (sz_byte) begin
                be_new    = 4'b0001 << ALU_in[1:0];
                wdata_new = {4{store_data_in[7:0]}};
            end else if (sz_half) begin
                be_new    = ALU_in[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data_in[15:0]}};
            end
        end
    end

    always_comb begin
        rd_byte = dm_rdata[8*off_q +: 8];
        rd_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = dm_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ldata_d = ldata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    addr_d  = {ALU_in[31:2], 2'b00};
                    we_d    = MemWrite_in;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = funct3_in;
                    off_d   = ALU_in[1:0];
                    tmo_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (dm_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) ldata_d = rd_ext;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!we_q) ldata_d = 32'd0;
                end else if (tmo_q != 8'hFF) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
            ldata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ldata_q <= ldata_d;
        end
    end

    // Input-driven outputs are gated by reset so an in-flight access vanishes the moment reset hits.
    assign stall_out        = rst & (start | in_wait);
    assign misalign_err_out = rst & in_idle & access & misaligned;
    assign dm_req           = in_wait;
    assign dm_we            = in_wait & we_q;
    assign dm_addr          = addr_q;
    assign dm_be            = be_q;
    assign dm_wdata         = wdata_q;
    assign load_valid_out   = in_done & ~we_q;
    assign bus_err_out      = in_done & err_q;
    assign load_data_out    = ldata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level timeline model checked every cycle, plus literal spot checks.
module tb_mem_access_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead_in = 1'b0;
    logic        MemWrite_in = 1'b0;
    logic [31:0] ALU_in = 32'd0;
    logic [31:0] store_data_in = 32'd0;
    logic [2:0]  funct3_in = 3'd0;
    logic        stall_out, load_valid_out, misalign_err_out, bus_err_out;
    logic [31:0] load_data_out;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALU_in(ALU_in), .store_data_in(store_data_in), .funct3_in(funct3_in),
        .stall_out(stall_out), .load_data_out(load_data_out), .load_valid_out(load_valid_out),
        .misalign_err_out(misalign_err_out), .bus_err_out(bus_err_out),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec rules as plain arithmetic) ----------------
    logic [31:0] mem [0:255];

    function automatic int acc_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] m;
        if (!st || acc_bytes(f3) == 4) return 4'hF;
        m = ((acc_bytes(f3) == 1) ? 32'd1 : 32'd3) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
        case (acc_bytes(f3))
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> (8 * (a % 4));
        case (f3)
            3'd0:    return sh[7]  ? (sh & 32'hFF) - 32'h100 : (sh & 32'hFF);
            3'd1:    return sh[15] ? (sh & 32'hFFFF) - 32'h1_0000 : (sh & 32'hFFFF);
            3'd4:    return sh & 32'hFF;
            3'd5:    return sh & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    int   ack_after = 0;
    logic late_ack  = 1'b0;
    int   req_cnt   = 0;
    always @(negedge clk) begin
        logic hit;
        hit = 1'b0;
        if (dm_req) begin
            req_cnt  = req_cnt + 1;
            hit      = (req_cnt == ack_after + 1);
            dm_rdata = mem[dm_addr[9:2]];
        end else begin
            req_cnt  = 0;
            dm_rdata = 32'h5A5A_5A5A;
        end
        dm_ack = hit | late_ack;
    end

    // ---------------- monitor counters / captures ----------------
    int stall_n = 0, req_n = 0, mis_n = 0, lv_n = 0;
    logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0;
    logic [3:0]  cap_be = 4'd0;
    logic        cap_we = 1'b0;
    always @(negedge clk) begin
        if (stall_out) stall_n++;
        if (misalign_err_out) mis_n++;
        if (load_valid_out) lv_n++;
        if (dm_req) begin
            req_n++;
            cap_addr  = dm_addr;
            cap_wdata = dm_wdata;
            cap_be    = dm_be;
            cap_we    = dm_we;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_lvalid, exp_mis, exp_berr;
    logic [31:0] exp_addr, exp_wdata, exp_ldata;
    logic [3:0]  exp_be;
    logic [31:0] last_ldata = 32'd0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("stall_out", stall_out, exp_stall);
            chk1("dm_req", dm_req, exp_req);
            chk1("load_valid_out", load_valid_out, exp_lvalid);
            chk1("misalign_err_out", misalign_err_out, exp_mis);
            chk1("bus_err_out", bus_err_out, exp_berr);
            chk32("load_data_out", load_data_out, exp_ldata);
            if (exp_req) begin
                chk1("dm_we", dm_we, exp_we);
                chk32("dm_addr", dm_addr, exp_addr);
                chk32("dm_be", {28'd0, dm_be}, {28'd0, exp_be});
                if (exp_we) chk32("dm_wdata", dm_wdata, exp_wdata);
            end
        end
    end

    // ---------------- driver ----------------
    int b_stall, b_req, b_mis, b_lv;

    task automatic snap();
        b_stall = stall_n; b_req = req_n; b_mis = mis_n; b_lv = lv_n;
    endtask

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0;
        exp_be = 4'd0; exp_wdata = 32'd0; exp_lvalid = 1'b0; exp_mis = 1'b0;
        exp_berr = 1'b0; exp_ldata = last_ldata;
    endtask

    task automatic set_wait_exp(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        set_idle_exp();
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = st;
        exp_addr  = a - (a % 4);
        exp_be    = model_be(st, a, f3);
        exp_wdata = model_wdata(d, f3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemRead_in = 1'b0; MemWrite_in = 1'b0;
            set_idle_exp();
        end
    endtask

    // Presents one access and walks the expected timeline; returns #1 into DONE (or the misaligned cycle).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f3, input int delay);
        logic mis, err;
        logic [31:0] rword;
        logic [3:0]  be;
        logic [31:0] wd;
        int wait_n;
        mis = ((a % acc_bytes(f3)) != 0);
        @(posedge clk); #1;
        MemRead_in = rd; MemWrite_in = wr; ALU_in = a; store_data_in = d; funct3_in = f3;
        ack_after = delay;
        snap();
        set_idle_exp();
        exp_stall = !mis;
        exp_mis   = mis;
        if (!mis) begin
            rword = mem[a[9:2]];
            be    = model_be(wr, a, f3);
            wd    = model_wdata(d, f3);
            err   = (TMO != 0) && (delay + 1 > TMO);
            wait_n = err ? TMO : delay + 1;
            for (int i = 0; i < wait_n; i++) begin
                @(posedge clk); #1;
                set_wait_exp(wr, a, d, f3);
            end
            @(posedge clk); #1;
            if (!wr) last_ldata = err ? 32'd0 : model_ext(rword, a, f3);
            set_idle_exp();
            exp_lvalid = !wr;
            exp_berr   = err;
            if (wr && !err)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[64] = 32'hDEAD_BEEF;
        set_idle_exp();

        // Reset state
        #3 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk1("rst stall_out", stall_out, 1'b0);
        chk1("rst dm_req", dm_req, 1'b0);
        chk1("rst dm_we", dm_we, 1'b0);
        chk1("rst load_valid_out", load_valid_out, 1'b0);
        chk1("rst misalign_err_out", misalign_err_out, 1'b0);
        chk1("rst bus_err_out", bus_err_out, 1'b0);
        chk32("rst dm_addr", dm_addr, 32'd0);
        chk32("rst dm_be", {28'd0, dm_be}, 32'd0);
        chk32("rst dm_wdata", dm_wdata, 32'd0);
        chk32("rst load_data_out", load_data_out, 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // LW 0x100, minimum latency
        do_access(1'b1, 1'b0, 32'h100, 32'd0, 3'b010, 0);
        chk32("lw data", load_data_out, 32'hDEAD_BEEF);
        chk1("lw valid", load_valid_out, 1'b1);
        idle(1);
        chk32("lw stall cycles", stall_n - b_stall, 32'd2);
        chk32("lw req cycles", req_n - b_req, 32'd1);

        // Sub-word loads, back-to-back
        mem[64] = 32'h80FF_0000;
        do_access(1'b1, 1'b0, 32'h103, 32'd0, 3'b000, 0);
        chk32("lb 0x103", load_data_out, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 32'h103, 32'd0, 3'b100, 1);
        chk32("lbu 0x103", load_data_out, 32'h0000_0080);
        do_access(1'b1, 1'b0, 32'h102, 32'd0, 3'b101, 0);
        chk32("lhu 0x102", load_data_out, 32'h0000_80FF);
        do_access(1'b1, 1'b0, 32'h102, 32'd0, 3'b001, 2);
        chk32("lh 0x102", load_data_out, 32'hFFFF_80FF);
        idle(1);

        // SB to 0x201
        do_access(1'b0, 1'b1, 32'h201, 32'h1234_5678, 3'b000, 1);
        idle(1);
        chk1("sb dm_we", cap_we, 1'b1);
        chk32("sb dm_addr", cap_addr, 32'h200);
        chk32("sb dm_be", {28'd0, cap_be}, 32'b0010);
        chk32("sb dm_wdata", cap_wdata, 32'h7878_7878);

        // Misaligned SH: no request, no stall
        do_access(1'b0, 1'b1, 32'h203, 32'h0000_ABCD, 3'b001, 0);
        idle(2);
        chk32("sh mis pulses", mis_n - b_mis, 32'd1);
        chk32("sh mis req", req_n - b_req, 32'd0);
        chk32("sh mis stall", stall_n - b_stall, 32'd0);

        // Store then reload, including ack on the last cycle before timeout
        do_access(1'b0, 1'b1, 32'h300, 32'hA5A5_1234, 3'b010, 2);
        do_access(1'b1, 1'b0, 32'h300, 32'd0, 3'b010, TMO - 1);
        chk32("lw after sw", load_data_out, 32'hA5A5_1234);
        chk1("ack at limit no err", bus_err_out, 1'b0);
        do_access(1'b1, 1'b0, 32'h302, 32'd0, 3'b001, 0);
        chk32("lh 0x302", load_data_out, 32'hFFFF_A5A5);
        do_access(1'b1, 1'b0, 32'h300, 32'd0, 3'b011, 0);
        chk32("f3=011 as word", load_data_out, 32'hA5A5_1234);
        do_access(1'b1, 1'b0, 32'h302, 32'd0, 3'b111, 0);
        do_access(1'b1, 1'b0, 32'h101, 32'd0, 3'b010, 0);
        do_access(1'b1, 1'b0, 32'h101, 32'd0, 3'b001, 0);
        do_access(1'b1, 1'b0, 32'h101, 32'd0, 3'b101, 0);
        do_access(1'b1, 1'b0, 32'h102, 32'd0, 3'b000, 0);
        chk32("lb 0x102", load_data_out, 32'hFFFF_FFFF);
        idle(1);

        // Read+write together is a store
        do_access(1'b1, 1'b1, 32'h304, 32'h0000_BEEF, 3'b001, 0);
        idle(1);
        chk1("rw store dm_we", cap_we, 1'b1);
        chk32("rw store dm_be", {28'd0, cap_be}, 32'b0011);
        chk32("rw store dm_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk32("rw store no lvalid", lv_n - b_lv, 32'd0);

        // Timeout
        do_access(1'b1, 1'b0, 32'h100, 32'd0, 3'b010, 1000);
        chk1("tmo bus_err_out", bus_err_out, 1'b1);
        chk32("tmo load_data_out", load_data_out, 32'd0);
        idle(1);
        chk32("tmo req cycles", req_n - b_req, TMO);

        // Reset in the second WAIT cycle, then a late ack
        @(posedge clk); #1;
        MemRead_in = 1'b1; MemWrite_in = 1'b0; ALU_in = 32'h100; funct3_in = 3'b010;
        ack_after = 5;
        set_idle_exp(); exp_stall = 1'b1;
        @(posedge clk); #1;
        set_wait_exp(1'b0, 32'h100, 32'd0, 3'b010);
        @(posedge clk); #1;
        set_wait_exp(1'b0, 32'h100, 32'd0, 3'b010);
        #2;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        chk1("rst mid-wait dm_req", dm_req, 1'b0);
        chk1("rst mid-wait stall_out", stall_out, 1'b0);
        @(posedge clk); #1;
        MemRead_in = 1'b0;
        last_ldata = 32'd0;
        @(negedge clk); #1;
        rst = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        snap();
        @(posedge clk); #1;
        late_ack = 1'b1;
        idle(2);
        late_ack = 1'b0;
        idle(2);
        chk32("late ack lvalid", lv_n - b_lv, 32'd0);
        chk32("late ack req", req_n - b_req, 32'd0);
        chk32("late ack data", load_data_out, 32'd0);

        // Normal operation after recovery
        do_access(1'b1, 1'b0, 32'h103, 32'd0, 3'b100, 0);
        chk32("lbu after reset", load_data_out, 32'h0000_0080);
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
